// File: rtl/jtsdram_bank_rd.sv
// Bank read-verify engine: walks LEN SDRAM words, checks each against a keyed pattern.
// One request outstanding at a time; err/err_cnt accumulate until reset.
module jtsdram_bank_rd #(
  parameter int         AW   = 22,
  parameter int         LEN  = 256,
  parameter logic [7:0] TOUT = 8'd255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_start,
  input  logic [4:0]    key,
  input  logic [15:0]   data_ref,
  output logic          done,
  output logic          ba_rd,
  output logic [AW-1:0] ba_addr,
  input  logic          ba_ack,
  input  logic          ba_dst,
  input  logic [15:0]   ba_dout,
  output logic          err,
  output logic [7:0]    err_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [AW-1:0] LAST = AW'(LEN - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] i_q, i_d;
  logic [4:0]    key_q, key_d;
  logic [15:0]   ref_q, ref_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          start, tout_hit, finish, mismatch;
  logic [15:0]   seed, rot, exp_word;
  logic [31:0]   dbl;

  // Expected word: rotate-left of (index ^ seed) by key[3:0], optional inversion.
  always_comb begin
    seed     = 16'(i_q) ^ ref_q;
    dbl      = {seed, seed} << key_q[3:0];
    rot      = dbl[31:16];
    exp_word = key_q[4] ? ~rot : rot;
  end

  always_comb begin
    start    = rd_start && (state_q == IDLE || state_q == DONE);
    tout_hit = (state_q == WAIT) && !ba_dst && (tcnt_q == TOUT - 8'd1);
    finish   = (state_q == WAIT) && (ba_dst || tout_hit);
    mismatch = ba_dst ? (ba_dout != exp_word) : tout_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      i_q       <= '0;
      key_q     <= '0;
      ref_q     <= '0;
      tcnt_q    <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      key_q     <= key_d;
      ref_q     <= ref_d;
      tcnt_q    <= tcnt_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = REQ;
      REQ:        if (ba_ack) state_d = WAIT;
      WAIT:       if (finish) state_d = (i_q == LAST) ? DONE : REQ;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    i_d       = i_q;
    key_d     = key_q;
    ref_d     = ref_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    // Timer holds at zero while requesting, so it is cleared on the ack edge.
    tcnt_d    = (state_q == WAIT) ? tcnt_q + 8'd1 : 8'd0;
    if (start) begin
      i_d   = '0;
      key_d = key;
      ref_d = data_ref;
    end
    if (finish) begin
      if (mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
      end
      if (i_q != LAST) i_d = i_q + 1'b1;
    end
  end

  always_comb begin
    ba_rd   = (state_q == REQ);
    done    = (state_q == DONE);
    ba_addr = i_q;
    err     = err_q;
    err_cnt = err_cnt_q;
  end

endmodule

// File: tb/tb_jtsdram_bank_rd.sv
// Directed bench for jtsdram_bank_rd with an SDRAM responder and an address scoreboard.
module tb_jtsdram_bank_rd;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_start;
  logic [4:0]  key;
  logic [15:0] data_ref;
  logic        done;
  logic        ba_rd;
  logic [21:0] ba_addr;
  logic        ba_ack;
  logic        ba_dst;
  logic [15:0] ba_dout;
  logic        err;
  logic [7:0]  err_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [4:0]  m_key = '0;
  logic [15:0] m_ref = '0;
  logic [3:0]  corrupt_mask = '0;
  logic [3:0]  drop_mask = '0;
  logic        hold_ack = 1'b0;
  int          exp_q[$];

  jtsdram_bank_rd #(.AW(22), .LEN(4), .TOUT(8'd8)) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start), .key(key), .data_ref(data_ref),
    .done(done), .ba_rd(ba_rd), .ba_addr(ba_addr), .ba_ack(ba_ack), .ba_dst(ba_dst),
    .ba_dout(ba_dout), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Pattern built bit by bit: bit b of (idx ^ seed) lands at position b+k mod 16.
  function automatic logic [15:0] ref_word(input logic [15:0] idx, input logic [4:0] k,
                                           input logic [15:0] r);
    logic [15:0] x;
    logic [15:0] y;
    x = idx ^ r;
    y = '0;
    for (int b = 0; b < 16; b++) y[4'(b + int'(k[3:0]))] = x[b];
    return k[4] ? ~y : y;
  endfunction

  // SDRAM model: ack one cycle after seeing ba_rd, data three cycles after ack.
  initial begin
    logic [21:0] a;
    ba_ack  = 1'b0;
    ba_dst  = 1'b0;
    ba_dout = '0;
    forever begin
      @(negedge clk);
      if (ba_rd === 1'b1 && rst === 1'b0 && !hold_ack) begin
        a = ba_addr;
        check("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("req_addr", 32'(a), 32'(exp_q.pop_front()));
        ba_ack = 1'b1;
        @(negedge clk);
        ba_ack = 1'b0;
        if (!drop_mask[a[1:0]]) begin
          repeat (2) @(negedge clk);
          ba_dst  = 1'b1;
          ba_dout = ref_word(16'(a), m_key, m_ref) ^ (corrupt_mask[a[1:0]] ? 16'h0040 : 16'h0000);
          @(negedge clk);
          ba_dst  = 1'b0;
        end
      end
    end
  end

  task automatic start_pass(input logic [4:0] k, input logic [15:0] r);
    @(negedge clk);
    m_key    = k;
    m_ref    = r;
    key      = k;
    data_ref = r;
    for (int w = 0; w < 4; w++) exp_q.push_back(w);
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    key      = '0;
    data_ref = '0;
    check("done_drops_on_start", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check(tag, 32'(done), 32'd1);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int done_seen;
    rst      = 1'b1;
    rd_start = 1'b0;
    key      = '0;
    data_ref = '0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ba_rd", 32'(ba_rd), 32'd0);
    check("rst_ba_addr", 32'(ba_addr), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    // Plain pattern: words aaaa, aaab, aaa8, aaa9.
    start_pass(5'h00, 16'haaaa);
    wait_done("pass_plain");
    check("plain_err", 32'(err), 32'd0);
    check("plain_err_cnt", 32'(err_cnt), 32'd0);

    // Rotated and inverted pattern (word 1 = fffd).
    start_pass(5'h11, 16'h0000);
    wait_done("pass_inv");
    check("inv_err", 32'(err), 32'd0);

    // rd_start during WAIT must not restart the pass.
    start_pass(5'h0b, 16'h1234);
    c = 0;
    while (c < 100) begin
      @(posedge clk); #1;
      if (ba_ack === 1'b1) break;
      c++;
    end
    check("ack_seen", 32'(c < 100), 32'd1);
    @(negedge clk);
    key      = 5'h1f;
    data_ref = 16'hffff;
    rd_start = 1'b1;
    @(negedge clk);
    rd_start = 1'b0;
    wait_done("pass_ignore_start");
    check("ignore_err", 32'(err), 32'd0);

    // Single corrupted word, then a clean pass keeps the sticky state.
    corrupt_mask = 4'b0100;
    start_pass(5'h03, 16'h5a5a);
    wait_done("pass_corrupt");
    check("corrupt_err", 32'(err), 32'd1);
    check("corrupt_err_cnt", 32'(err_cnt), 32'd1);
    corrupt_mask = 4'b0000;
    start_pass(5'h07, 16'h0f0f);
    wait_done("pass_clean_after");
    check("sticky_err", 32'(err), 32'd1);
    check("sticky_err_cnt", 32'(err_cnt), 32'd1);

    // Dropped data strobe on word 0 times out after exactly 8 cycles.
    do_reset();
    check("rst2_err", 32'(err), 32'd0);
    drop_mask = 4'b0001;
    start_pass(5'h00, 16'h0001);
    c = 0;
    while (c < 100) begin
      @(posedge clk); #1;
      if (ba_ack === 1'b1) break;
      c++;
    end
    c = 0;
    while (c < 20) begin
      @(posedge clk); #1;
      c++;
      if (err === 1'b1) break;
    end
    check("tout_cycles", 32'(c), 32'd8);
    check("tout_err_cnt", 32'(err_cnt), 32'd1);
    check("tout_next_rd", 32'(ba_rd), 32'd1);
    check("tout_next_addr", 32'(ba_addr), 32'd1);
    wait_done("pass_tout");
    check("tout_final_cnt", 32'(err_cnt), 32'd1);
    drop_mask = 4'b0000;

    // Reset in REQ aborts at once and no done follows.
    hold_ack = 1'b1;
    start_pass(5'h00, 16'h0000);
    c = 0;
    while (c < 20 && ba_rd !== 1'b1) begin
      @(posedge clk); #1;
      c++;
    end
    check("abort_in_req", 32'(ba_rd), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ba_rd", 32'(ba_rd), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    hold_ack = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    check("abort_idle_rd", 32'(ba_rd), 32'd0);

    // 300 mismatches: count reaches 252, then saturates at 255.
    corrupt_mask = 4'b1111;
    repeat (63) begin
      start_pass(5'h09, 16'hc3c3);
      wait_done("pass_sat");
    end
    check("sat_252", 32'(err_cnt), 32'd252);
    start_pass(5'h09, 16'hc3c3);
    wait_done("pass_sat_edge");
    check("sat_255", 32'(err_cnt), 32'd255);
    repeat (11) begin
      start_pass(5'h15, 16'h3c3c);
      wait_done("pass_sat_more");
    end
    check("sat_hold", 32'(err_cnt), 32'd255);
    check("sat_err", 32'(err), 32'd1);
    corrupt_mask = 4'b0000;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/jtsdram_bank_rd.md
JTSDRAM_BANK_RD -- requirements
Module: jtsdram_bank_rd

Interface
REQ-001 Parameter AW, default 22: SDRAM word-address width.
REQ-002 Parameter LEN, default 256: number of words read per pass, 1..2^AW.
REQ-003 Parameter TOUT, default 255: max cycles from ack to data strobe, 8-bit.
REQ-004 clk  in  1  clock; reset rst, asynchronous, active-high.
REQ-005 rd_start  in  1  one-cycle pass request from the test sequencer.
REQ-006 key  in  5  bank scramble key, sampled when rd_start is accepted.
REQ-007 data_ref  in  16  pass seed, sampled when rd_start is accepted.
REQ-008 done  out  1  high = idle with last pass complete.
REQ-009 ba_rd  out  1  read request to the SDRAM controller.
REQ-010 ba_addr  out  AW  word address of the current request.
REQ-011 ba_ack  in  1  one-cycle pulse: request accepted.
REQ-012 ba_dst  in  1  one-cycle pulse: ba_dout valid.
REQ-013 ba_dout  in  16  read data.
REQ-014 err  out  1  sticky mismatch or timeout flag.
REQ-015 err_cnt  out  8  saturating error count.

Function
REQ-016 States: IDLE, REQ, WAIT, DONE; DONE and IDLE are the only states with no request outstanding.
REQ-017 In IDLE or DONE, rd_start=1 on an edge latches key/data_ref, clears index i to 0, enters REQ, and drops done on that same edge.
REQ-018 rd_start while in REQ or WAIT is ignored; the pass is not restarted.
REQ-019 In REQ: ba_rd=1 and ba_addr=i, zero-extended to AW; both are held stable until ba_ack.
REQ-020 On ba_ack in REQ: ba_rd drops on that edge, the timeout counter clears, and the state moves to WAIT.
REQ-021 ba_dst outside WAIT is ignored; ba_ack outside REQ is ignored.
REQ-022 Expected word: exp = rotl16(i[15:0] ^ data_ref_latched, key[3:0]), then inverted if key[4]=1.
REQ-023 On ba_dst in WAIT: ba_dout != exp sets err, and err_cnt increments if below 255.
REQ-024 After the REQ-023 compare: if i=LEN-1 the state goes to DONE with done=1; otherwise i increments and the state returns to REQ on the next edge.
REQ-025 Requests are back-to-back: one idle cycle (the WAIT exit) separates consecutive ba_rd assertions at minimum.
REQ-026 If WAIT lasts TOUT cycles without ba_dst, the block sets err, counts one error, and advances as in REQ-024.
REQ-027 err_cnt saturates at 255; err stays high until reset.
REQ-028 done is registered; combinational paths from inputs to outputs are forbidden.

Reset
REQ-029 rst high forces IDLE, done=0, ba_rd=0, ba_addr=0, err=0, err_cnt=0, i=0, and clears the latched key and data_ref.
REQ-030 rst asserted mid-pass aborts the pass immediately; no done pulse follows release.

Verification
REQ-031 LEN=4, key=0, data_ref=16'haaaa, model returns exp after 3 cycles -> reads addr 0..3 with data aaaa,aaab,aaa8,aaa9; err=0; done=1 after the 4th ba_dst.
REQ-032 key=5'h11, data_ref=0, i=1 -> exp=~rotl(0001,1)=16'hfffd; a correct model gives err=0.
REQ-033 Model corrupts word 2 only -> err=1 and err_cnt=1 after the pass; a second clean pass leaves err=1 and err_cnt=1.
REQ-034 Model drops ba_dst for word 0, TOUT=8 -> 8 cycles after ack, err=1, err_cnt=1, and addr 1 is requested next.
REQ-035 rd_start pulsed during WAIT -> ignored, the pass completes normally; rst during REQ -> ba_rd=0 and done=0 at once.
REQ-036 300 forced mismatches -> err_cnt=255.
